// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl upload server.
package ioctl_pkg;
  typedef enum logic [1:0] {IDLE, READ, DONE} upl_state_t;
  localparam int         IOCTL_AW  = 25;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
endpackage

// File: rtl/upload_req_hs.sv
// Upload request latch toward hps_io, registered sel edge detect and the
// optional autosave idle timer (built only with UPLOAD_AUTOSAVE_EN defined).
module upload_req_hs #(
  parameter logic [23:0] IDLE_CYC = 24'd2400000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sel,
  input  logic save_req,
  input  logic mem_wr_mon,
  output logic busy,
  output logic upload_req
);
  logic sel_q, sel_qq;
  logic busy_rise;
  logic save_int;

  // busy has risen one clock ago; the request drops on this clock
  assign busy_rise = sel_q & ~sel_qq;
  assign busy      = sel_q;

`ifdef UPLOAD_AUTOSAVE_EN
  logic        dirty;
  logic        wr_held;
  logic [23:0] idle_cnt;

  // dirty tracking: writes during an upload are held and re-arm afterwards
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty    <= 1'b0;
      wr_held  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (mem_wr_mon && sel) wr_held <= 1'b1;
      if (mem_wr_mon && !sel) begin
        dirty    <= 1'b1;
        idle_cnt <= IDLE_CYC;
      end else if (wr_held && !sel) begin
        dirty    <= 1'b1;
        idle_cnt <= IDLE_CYC;
        wr_held  <= 1'b0;
      end else if (busy_rise) begin
        dirty    <= 1'b0;
      end else if (dirty && idle_cnt != 24'd0) begin
        idle_cnt <= idle_cnt - 24'd1;
      end
    end
  end

  assign save_int = save_req | (dirty && idle_cnt == 24'd0);
`else
  assign save_int = save_req;
  logic unused_autosave;
  assign unused_autosave = &{1'b0, mem_wr_mon, IDLE_CYC};
`endif

  // request latch: set by a save outside an upload, cleared after busy rises
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 1'b0;
      sel_qq     <= 1'b0;
      upload_req <= 1'b0;
    end else begin
      sel_q  <= sel;
      sel_qq <= sel_q;
      if (busy_rise)            upload_req <= 1'b0;
      else if (save_int && !sel) upload_req <= 1'b1;
    end
  end
endmodule

// File: rtl/ioctl_upload_server.sv
// Core-side responder for hps_io uploads: serves byte reads from core memory
// with a fixed-latency read FSM and raises the upload request handshake.
// Optional autosave timer: define UPLOAD_AUTOSAVE_EN.
module ioctl_upload_server
  import ioctl_pkg::*;
#(
  parameter int          AW           = 17,
  parameter int          SIZE         = 8192,
  parameter int          RD_LAT       = 2,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd5,
  parameter logic [23:0] IDLE_CYC     = 24'd2400000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                save_req,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                ioctl_upload_req,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_q,
  input  logic                mem_wr_mon,
  output logic                busy
);
  localparam logic [IOCTL_AW-1:0] SIZE_L = IOCTL_AW'(SIZE);
  localparam logic [2:0]          LAT_L  = 3'(RD_LAT);

  upl_state_t state;
  logic [2:0] lat_cnt;
  logic       sel;
  logic       in_range;

  assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign in_range = ioctl_addr < SIZE_L;

  upload_req_hs #(.IDLE_CYC(IDLE_CYC)) u_req_hs (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sel        (sel),
    .save_req   (save_req),
    .mem_wr_mon (mem_wr_mon),
    .busy       (busy),
    .upload_req (ioctl_upload_req)
  );

  // read FSM: strobe -> memory read -> wait out latency -> return byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      ioctl_wait <= 1'b0;
      ioctl_din  <= '0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (ioctl_rd && sel) begin
            ioctl_wait <= 1'b1;
            if (in_range) begin
              mem_addr <= ioctl_addr[AW-1:0];
              mem_rd   <= 1'b1;
              lat_cnt  <= LAT_L;
              state    <= READ;
            end else begin
              // past the image: answer with fill, no memory access
              ioctl_din <= FILL_BYTE;
              state     <= DONE;
            end
          end
        end
        READ: begin
          if (!sel) begin
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else if (lat_cnt == 3'd0) begin
            ioctl_din  <= mem_q;
            ioctl_wait <= 1'b0;
            state      <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        DONE: begin
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: table of read vectors checked through a
// scoreboard queue, plus hand sequences for handshake, abort and reset.
module tb_ioctl_upload_server;
  localparam int RD_LAT = 2;
  localparam int SIZE   = 8192;

  logic        clk_sys, reset_n, save_req, ioctl_upload, ioctl_rd;
  logic [7:0]  ioctl_index, ioctl_din, mem_q;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, ioctl_upload_req, mem_rd, mem_wr_mon, busy;
  logic [16:0] mem_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        upload;
    logic [7:0]  index;
    logic [24:0] addr;
    logic        exp_busy;
    logic        exp_rd;
    logic [16:0] exp_maddr;
    int          exp_wait;
    logic [7:0]  exp_din;
  } rd_vec_t;

  rd_vec_t vecs [8];
  rd_vec_t sb_q [$];
  logic [7:0] mem [SIZE];
  logic [7:0] q_pipe [RD_LAT];

  ioctl_upload_server #(
    .AW(17), .SIZE(SIZE), .RD_LAT(RD_LAT), .UPLOAD_INDEX(8'd5), .IDLE_CYC(24'd100)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .save_req(save_req),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_q(mem_q), .mem_wr_mon(mem_wr_mon), .busy(busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // memory model: RD_LAT-deep registered read path
  always @(posedge clk_sys) begin
    q_pipe[0] <= mem_rd ? mem[mem_addr[12:0]] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // drive one read strobe, observe a fixed window, score against the queue
  task automatic do_vec(input rd_vec_t v, input int id);
    int wcnt, rcnt;
    logic [16:0] ra;
    logic [7:0] din_fall;
    logic prev_w, got_fall;
    rd_vec_t e;
    @(negedge clk_sys);
    ioctl_upload = v.upload;
    ioctl_index  = v.index;
    @(negedge clk_sys);
    chk($sformatf("v%0d_busy", id), busy, v.exp_busy);
    sb_q.push_back(v);
    ioctl_addr = v.addr;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wcnt = 0; rcnt = 0; ra = '0; prev_w = 1'b0; got_fall = 1'b0; din_fall = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk_sys);
      if (ioctl_wait) wcnt++;
      if (mem_rd) begin rcnt++; ra = mem_addr; end
      if (prev_w && !ioctl_wait && !got_fall) begin din_fall = ioctl_din; got_fall = 1'b1; end
      prev_w = ioctl_wait;
    end
    if (!got_fall) din_fall = ioctl_din;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL v%0d_scoreboard actual=empty expected=entry", id);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("v%0d_mem_rd_count", id), rcnt, e.exp_rd ? 1 : 0);
      if (e.exp_rd) chk($sformatf("v%0d_mem_addr", id), ra, e.exp_maddr);
      chk($sformatf("v%0d_wait_cycles", id), wcnt, e.exp_wait);
      chk($sformatf("v%0d_din", id), din_fall, e.exp_din);
      chk($sformatf("v%0d_din_hold", id), ioctl_din, e.exp_din);
    end
  endtask

  initial begin
    int rise_t;
    rd_vec_t vx;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'((i * 7) ^ (i >> 5) ^ 8'h3C);
    mem[16] = 8'hA5;

    vecs[0] = '{1'b1, 8'd5, 25'h10,      1'b1, 1'b1, 17'h10,   3, 8'hA5};
    vecs[1] = '{1'b1, 8'd5, 25'd8192,    1'b1, 1'b0, 17'h0,    1, 8'hFF};
    vecs[2] = '{1'b1, 8'd5, 25'd8191,    1'b1, 1'b1, 17'd8191, 3, mem[8191]};
    vecs[3] = '{1'b1, 8'd3, 25'h10,      1'b0, 1'b0, 17'h0,    0, mem[8191]};
    vecs[4] = '{1'b1, 8'd5, 25'h0,       1'b1, 1'b1, 17'h0,    3, mem[0]};
    vecs[5] = '{1'b1, 8'd5, 25'h0020010, 1'b1, 1'b0, 17'h0,    1, 8'hFF};
    vecs[6] = '{1'b0, 8'd5, 25'h20,      1'b0, 1'b0, 17'h0,    0, 8'hFF};
    vecs[7] = '{1'b1, 8'd5, 25'h1234,    1'b1, 1'b1, 17'h1234, 3, mem[16'h1234]};

    reset_n = 1'b1; save_req = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; mem_wr_mon = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_din", ioctl_din, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_req", ioctl_upload_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // request handshake
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    chk("hs_req_set", ioctl_upload_req, 1);
    repeat (3) @(negedge clk_sys);
    chk("hs_req_held", ioctl_upload_req, 1);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    chk("hs_req_idempotent", ioctl_upload_req, 1);
    ioctl_upload = 1'b1; ioctl_index = 8'd5;
    @(negedge clk_sys);
    chk("hs_busy_rise", busy, 1);
    chk("hs_req_still_up", ioctl_upload_req, 1);
    @(negedge clk_sys);
    chk("hs_req_cleared", ioctl_upload_req, 0);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    chk("hs_save_ignored_sel", ioctl_upload_req, 0);

    // table-driven reads
    for (int i = 0; i < 8; i++) do_vec(vecs[i], i);

    // abort: sel falls while READ is waiting on memory
    ioctl_upload = 1'b1; ioctl_index = 8'd5;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'h20; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("abort_wait_pre", ioctl_wait, 1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_wait_drop", ioctl_wait, 0);
    repeat (3) @(negedge clk_sys);
    chk("abort_din_kept", ioctl_din, mem[16'h1234]);
    chk("abort_no_wait", ioctl_wait, 0);
    vx = '{1'b1, 8'd5, 25'h30, 1'b1, 1'b1, 17'h30, 3, mem[16'h30]};
    do_vec(vx, 8);

`ifdef UPLOAD_AUTOSAVE_EN
    // autosave: writes at t=0 and t=50, quiet period 100
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    rise_t = -1;
    mem_wr_mon = 1'b1;
    for (int t = 0; t < 300 && rise_t < 0; t++) begin
      @(negedge clk_sys);
      mem_wr_mon = (t == 49);
      if (ioctl_upload_req) rise_t = t;
    end
    mem_wr_mon = 1'b0;
    checks++;
    if (rise_t < 150 || rise_t > 152) begin
      failures++;
      $display("FAIL autosave_rise actual=%0d expected=151+-1", rise_t);
    end
    ioctl_upload = 1'b1; ioctl_index = 8'd5;
    repeat (3) @(negedge clk_sys);
    chk("autosave_req_cleared", ioctl_upload_req, 0);
`else
    rise_t = 0;
`endif

    // asynchronous reset in the middle of a read
    ioctl_upload = 1'b1; ioctl_index = 8'd5;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'h10; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    chk("mid_mem_rd_pre", mem_rd, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din", ioctl_din, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_req", ioctl_upload_req, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    vx = '{1'b1, 8'd5, 25'h55, 1'b1, 1'b1, 17'h55, 3, mem[16'h55]};
    do_vec(vx, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ioctl_upload_server.md
Name: ioctl_upload_server

Overview:
- Core-side responder for the HPS ioctl upload direction. Complements the download path, which writes BIOS, sprite and music images into the core.
- Serves byte reads from a core memory region, such as NVRAM or a high-score table, back to hps_io when the HPS saves a file.
- Generates the upload request handshake toward hps_io.
- Sits in emu between hps_io and the memory owned by `system`, in the clk_sys domain.

Parameters:
- AW, 17: byte address width into core memory; matches the `dn_addr` width.
- SIZE, 8192: number of valid bytes in the upload image.
- RD_LAT, 2: core memory read latency in clocks, 1..4.
- UPLOAD_INDEX, 8'd5: ioctl_index value this block answers.
- IDLE_CYC, 24'd2400000: autosave quiet period (100 ms at 24 MHz); used only with the optional feature.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- save_req  in  1  core pulse requesting an upload
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  selected file index
- ioctl_rd  in  1  one-cycle read strobe from hps_io
- ioctl_addr  in  25  byte address of the read
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  high while the read is pending
- ioctl_upload_req  out  1  request to hps_io to start an upload
- mem_addr  out  AW  core memory read address
- mem_rd  out  1  core memory read enable
- mem_q  in  8  core memory read data; valid RD_LAT clocks after mem_rd
- mem_wr_mon  in  1  core write strobe into the region; monitored only
- busy  out  1  upload active and selected

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Request latch, wait counter and idle counter cleared. Assertion takes effect immediately (asynchronous); deassertion is synchronised by the parent.
- sel = ioctl_upload && (ioctl_index == UPLOAD_INDEX). busy = sel, registered with 1 clock latency.
- Request handshake:
  - save_req sets ioctl_upload_req on the next clock.
  - ioctl_upload_req holds until the rising edge of sel is seen, then clears on the following clock.
  - save_req while sel is already high is ignored.
  - save_req while a request is already pending is idempotent.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - ioctl_rd && sel && ioctl_addr < SIZE: drive mem_addr = ioctl_addr[AW-1:0] and mem_rd = 1 for one clock, assert ioctl_wait, load the latency counter with RD_LAT, go to READ.
  - ioctl_rd && sel && ioctl_addr >= SIZE: out of range. ioctl_din = 8'hFF, ioctl_wait asserted for exactly 1 clock, no mem_rd, go to DONE.
  - ioctl_rd with sel low: ignored, outputs unchanged.
- READ:
  - Counter decrements each clock.
  - When it reaches 0, capture mem_q into ioctl_din, deassert ioctl_wait, go to DONE.
  - Total ioctl_wait high time = RD_LAT + 1 clocks from the strobe.
- DONE: ioctl_din holds its value; return to IDLE on the next clock.
- Strobe collisions: an ioctl_rd arriving in READ or DONE is dropped. hps_io guarantees it will not issue one while ioctl_wait is high.
- sel falling in READ: abort to IDLE, deassert ioctl_wait, leave ioctl_din unchanged.
- Address compare uses the full 25 bits; no wrap-around.
- mem_addr holds its last value when not reading.

Optional Feature:
- Macro: UPLOAD_AUTOSAVE_EN.
- With the macro defined:
  - A mem_wr_mon pulse sets a dirty flag and reloads a 24-bit idle counter to IDLE_CYC.
  - The counter decrements while dirty and no write occurs.
  - At 0 it generates an internal save_req, identical in effect to the external pulse.
  - The dirty flag clears on the rising edge of sel.
  - A write arriving while sel is high re-sets the flag after the upload completes, so a new autosave follows.
- Without the macro: mem_wr_mon is ignored, the counter and flag are not built, and only the external save_req triggers uploads.

Decomposition:
- Shared package ioctl_pkg holds:
  - typedef enum logic [1:0] {IDLE, READ, DONE} upl_state_t;
  - localparam IOCTL_AW = 25;
  - localparam FILL_BYTE = 8'hFF;
- One natural sub-module, upload_req_hs: the request latch, sel edge detect and optional autosave timer. The FSM and data path stay in the top.

Test Plan:
1. RD_LAT=2, UPLOAD_INDEX=5, sel high, memory[0x10]=8'hA5, ioctl_rd with ioctl_addr=0x10 -> mem_rd pulses 1 clock with mem_addr=0x10; ioctl_wait high 3 clocks; ioctl_din=8'hA5 when wait falls.
2. ioctl_addr=SIZE (8192) -> no mem_rd; ioctl_wait high 1 clock; ioctl_din=8'hFF.
3. save_req pulse with ioctl_upload low -> ioctl_upload_req=1 next clock and held; ioctl_upload=1 with index 5 -> req=0 one clock after busy rises.
4. ioctl_index=3 with ioctl_upload=1, ioctl_rd pulse -> no mem_rd, ioctl_wait stays 0, busy=0.
5. ioctl_upload drops mid-READ -> ioctl_wait=0 next clock, FSM in IDLE; the next valid strobe is served normally.
6. UPLOAD_AUTOSAVE_EN, IDLE_CYC=100: mem_wr_mon at t=0 and t=50 -> ioctl_upload_req rises at t=151±1, not before; reset_n low mid-READ -> all outputs 0 immediately.
